// File: rtl/exu.sv
// Execute unit: single-cycle ALU ops, bit-serial shifts, registered writeback.
// Forwards its pending writeback to a dependent bundle; sticky trap on bad bundle.
package exu_pkg;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam logic [2:0] FU_ALU = 3'd1;

  typedef struct packed {
    logic          invld_instr;
    logic          use_rd;
    logic          use_imm;
    logic          use_rs2;
    logic          use_rs1;
    logic [3:0]    alu_op;
    logic [2:0]    fu_id;
    logic [DW-1:0] imm;
    logic [DW-1:0] rs2_val;
    logic [DW-1:0] rs1_val;
    logic [RW-1:0] rd;
    logic [RW-1:0] rs2;
    logic [RW-1:0] rs1;
  } dyn_instr_t;

  localparam int DYN_W = $bits(dyn_instr_t);
endpackage

module exu
  import exu_pkg::*;
#(
  parameter int DATA_WIDTH     = DW,
  parameter int RD_LEN_STA     = RW,
  parameter int DYN_INST_WIDTH = DYN_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DYN_INST_WIDTH-1:0] dyn_instr_idu_i,
  input  logic                      dyn_vld_idu_i,
  output logic                      dyn_rdy_idu_o,
  output logic [RD_LEN_STA-1:0]     rd_exeu_o,
  output logic [DATA_WIDTH-1:0]     wrtbck_dat_exeu_o,
  output logic                      wrtbck_en_exeu_o,
  output logic                      busy_o,
  output logic                      trap_o
);

  typedef enum logic [1:0] {IDLE, SHIFT, WB} state_t;

  state_t state, state_n;
  dyn_instr_t ins;

  logic accept, bad, take, go_sh, go_wb;
  logic fwd1, fwd2, op_ok, is_shift;
  logic lt_s, lt_u, wb_go_en;
  logic [DATA_WIDTH-1:0] opa, opb, alu_res;
  logic [DATA_WIDTH-1:0] sh_reg, sh_nxt;
  logic [4:0] cnt, shamt;
  logic sh_right, sh_arith, pend_en;
  logic [RD_LEN_STA-1:0] pend_rd;

  assign ins = dyn_instr_t'(dyn_instr_idu_i);

  assign dyn_rdy_idu_o = (state != SHIFT) && !trap_o;
  assign busy_o = (state == SHIFT);
  assign accept = dyn_vld_idu_i && dyn_rdy_idu_o;

  // wrtbck_en already excludes x0, so a zero index never forwards
  assign fwd1 = (state == WB) && wrtbck_en_exeu_o
             && ins.use_rs1 && (ins.rs1 == rd_exeu_o);
  assign fwd2 = (state == WB) && wrtbck_en_exeu_o
             && ins.use_rs2 && (ins.rs2 == rd_exeu_o);

  assign opa = fwd1 ? wrtbck_dat_exeu_o : ins.rs1_val;
  assign opb = ins.use_imm ? ins.imm
             : (fwd2 ? wrtbck_dat_exeu_o : ins.rs2_val);
  assign shamt = opb[4:0];

  assign lt_s = $signed(opa) < $signed(opb);
  assign lt_u = opa < opb;

  always_comb begin
    alu_res  = '0;
    op_ok    = 1'b1;
    is_shift = 1'b0;
    case (ins.alu_op)
      4'b0000: alu_res = opa + opb;
      4'b1000: alu_res = opa - opb;
      4'b0001,
      4'b0101,
      4'b1101: begin
        is_shift = 1'b1;
        alu_res  = opa;
      end
      4'b0010: alu_res = {{(DATA_WIDTH-1){1'b0}}, lt_s};
      4'b0011: alu_res = {{(DATA_WIDTH-1){1'b0}}, lt_u};
      4'b0100: alu_res = opa ^ opb;
      4'b0110: alu_res = opa | opb;
      4'b0111: alu_res = opa & opb;
      default: op_ok = 1'b0;
    endcase
  end

  assign bad = ins.invld_instr || (ins.fu_id != FU_ALU) || !op_ok;
  assign take = accept && !bad;
  assign go_sh = take && is_shift && (shamt != 5'd0);
  assign go_wb = take && !go_sh;
  assign wb_go_en = ins.use_rd && (ins.rd != '0);

  assign sh_nxt = sh_right
    ? {sh_arith & sh_reg[DATA_WIDTH-1], sh_reg[DATA_WIDTH-1:1]}
    : {sh_reg[DATA_WIDTH-2:0], 1'b0};

  always_comb begin
    state_n = state;
    unique case (1'b1)
      state == SHIFT: if (cnt == 5'd1) state_n = WB;
      accept && bad:  state_n = IDLE;
      go_sh:          state_n = SHIFT;
      go_wb:          state_n = WB;
      default:        state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      rd_exeu_o         <= '0;
      wrtbck_dat_exeu_o <= '0;
      wrtbck_en_exeu_o  <= 1'b0;
      trap_o            <= 1'b0;
      sh_reg            <= '0;
      cnt               <= '0;
      sh_right          <= 1'b0;
      sh_arith          <= 1'b0;
      pend_rd           <= '0;
      pend_en           <= 1'b0;
    end else begin
      state            <= state_n;
      wrtbck_en_exeu_o <= 1'b0;
      if (accept && bad) trap_o <= 1'b1;
      if (go_sh) begin
        sh_reg   <= opa;
        cnt      <= shamt;
        sh_right <= ins.alu_op[2];
        sh_arith <= ins.alu_op[3];
        pend_rd  <= ins.rd;
        pend_en  <= wb_go_en;
      end
      if (go_wb) begin
        rd_exeu_o         <= ins.rd;
        wrtbck_dat_exeu_o <= alu_res;
        wrtbck_en_exeu_o  <= wb_go_en;
      end
      if (state == SHIFT) begin
        sh_reg <= sh_nxt;
        cnt    <= cnt - 5'd1;
        if (cnt == 5'd1) begin
          rd_exeu_o         <= pend_rd;
          wrtbck_dat_exeu_o <= sh_nxt;
          wrtbck_en_exeu_o  <= pend_en;
        end
      end
    end
  end

endmodule

// File: tb/tb_exu.sv
// Bench for exu: vector table plus hand sequences for forwarding,
// shift latency, trap and mid-shift reset; writebacks scored via a queue.
module tb_exu;
  import exu_pkg::*;

  logic            clk;
  logic            rst_n;
  dyn_instr_t      instr;
  logic            vld;
  logic            rdy;
  logic [4:0]      wb_rd;
  logic [31:0]     wb_dat;
  logic            wb_en;
  logic            busy;
  logic            trap;

  exu dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .dyn_instr_idu_i   (instr),
    .dyn_vld_idu_i     (vld),
    .dyn_rdy_idu_o     (rdy),
    .rd_exeu_o         (wb_rd),
    .wrtbck_dat_exeu_o (wb_dat),
    .wrtbck_en_exeu_o  (wb_en),
    .busy_o            (busy),
    .trap_o            (trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] dat;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ui;
    logic [4:0]  rd;
    logic        urd;
    logic        en;
    logic [31:0] dat;
  } vec_t;

  exp_t q[$];
  int checks = 0;
  int fails = 0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", n, act, want);
    end
  endtask

  function automatic dyn_instr_t mk(
    input logic [3:0] op, input logic [4:0] rd,
    input logic [4:0] rs1, input logic [31:0] a,
    input logic [4:0] rs2, input logic [31:0] b,
    input logic ui, input logic urd);
    dyn_instr_t r;
    r = '0;
    r.alu_op  = op;
    r.fu_id   = FU_ALU;
    r.rd      = rd;
    r.rs1     = rs1;
    r.rs2     = rs2;
    r.rs1_val = a;
    r.use_rs1 = 1'b1;
    r.use_rs2 = !ui;
    r.use_imm = ui;
    r.use_rd  = urd;
    r.imm     = ui ? b : 32'h00000BAD;
    r.rs2_val = ui ? 32'h0000DEAD : b;
    return r;
  endfunction

  // Returns on the negedge of the cycle after the accept edge.
  task automatic drive_accept(input dyn_instr_t b, input logic push,
                              input logic [4:0] erd,
                              input logic [31:0] edat);
    int k;
    exp_t e;
    instr = b;
    vld = 1'b1;
    k = 0;
    while (!rdy && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!rdy) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout got=rdy0 want=rdy1");
      vld = 1'b0;
      return;
    end
    @(posedge clk);
    if (push) begin
      e.rd = erd;
      e.dat = edat;
      q.push_back(e);
    end
    @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic drain(input string n);
    int k;
    k = 0;
    while (q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk(n, q.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && wb_en === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_wb got rd=%0d dat=%h want=none",
                 wb_rd, wb_dat);
      end else begin
        e = q.pop_front();
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
        chk("wb_dat", wb_dat, e.dat);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  vec_t vt[14];
  int bcnt;
  dyn_instr_t bi;

  initial begin
    vt[0]  = '{4'b0000, 32'd7, 32'd5, 1'b0, 5'd1, 1'b1, 1'b1, 32'd12};
    vt[1]  = '{4'b1000, 32'd0, 32'd1, 1'b0, 5'd2, 1'b1, 1'b1, 32'hFFFFFFFF};
    vt[2]  = '{4'b0010, 32'hFFFFFFFF, 32'd1, 1'b0, 5'd3, 1'b1, 1'b1, 32'd1};
    vt[3]  = '{4'b0011, 32'hFFFFFFFF, 32'd1, 1'b0, 5'd4, 1'b1, 1'b1, 32'd0};
    vt[4]  = '{4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 5'd5, 1'b1,
               1'b1, 32'h0FF00FF0};
    vt[5]  = '{4'b0110, 32'hF0F0F0F0, 32'h0F0F0000, 1'b0, 5'd6, 1'b1,
               1'b1, 32'hFFFFF0F0};
    vt[6]  = '{4'b0111, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 5'd7, 1'b1,
               1'b1, 32'hF000F000};
    vt[7]  = '{4'b0001, 32'd1, 32'h21, 1'b0, 5'd8, 1'b1, 1'b1, 32'd2};
    vt[8]  = '{4'b0101, 32'h80000000, 32'd3, 1'b1, 5'd9, 1'b1,
               1'b1, 32'h10000000};
    vt[9]  = '{4'b1101, 32'h80000010, 32'd4, 1'b1, 5'd10, 1'b1,
               1'b1, 32'hF8000001};
    vt[10] = '{4'b0000, 32'd3, 32'd4, 1'b0, 5'd0, 1'b1, 1'b0, 32'd0};
    vt[11] = '{4'b0000, 32'd3, 32'd4, 1'b0, 5'd12, 1'b0, 1'b0, 32'd0};
    vt[12] = '{4'b1000, 32'h80000000, 32'd1, 1'b1, 5'd13, 1'b1,
               1'b1, 32'h7FFFFFFF};
    vt[13] = '{4'b0000, 32'h10, 32'hFFFFFFFF, 1'b1, 5'd14, 1'b1,
               1'b1, 32'h0000000F};

    rst_n = 1'b0;
    vld = 1'b0;
    instr = '0;
    repeat (3) @(negedge clk);
    chk("rst_en", {31'd0, wb_en}, 0);
    chk("rst_rd", {27'd0, wb_rd}, 0);
    chk("rst_dat", wb_dat, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_trap", {31'd0, trap}, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_rdy", {31'd0, rdy}, 1);
    @(negedge clk);

    // ADDI x5, x0, -1
    drive_accept(mk(4'b0000, 5'd5, 5'd0, 32'd0, 5'd0, 32'hFFFFFFFF,
                    1'b1, 1'b1), 1'b1, 5'd5, 32'hFFFFFFFF);
    chk("addi_en", {31'd0, wb_en}, 1);
    chk("addi_rd", {27'd0, wb_rd}, 5);
    chk("addi_dat", wb_dat, 32'hFFFFFFFF);
    @(negedge clk);
    chk("addi_en_drop", {31'd0, wb_en}, 0);

    // back-to-back with rs1 then rs2 forwarding
    drive_accept(mk(4'b0000, 5'd3, 5'd0, 32'd7, 5'd0, 32'd5, 1'b0, 1'b1),
                 1'b1, 5'd3, 32'd12);
    chk("b2b_en1", {31'd0, wb_en}, 1);
    drive_accept(mk(4'b1000, 5'd4, 5'd3, 32'd0, 5'd0, 32'd2, 1'b1, 1'b1),
                 1'b1, 5'd4, 32'd10);
    chk("b2b_en2", {31'd0, wb_en}, 1);
    drive_accept(mk(4'b0000, 5'd8, 5'd0, 32'd100, 5'd4, 32'd0, 1'b0, 1'b1),
                 1'b1, 5'd8, 32'd110);
    chk("b2b_en3", {31'd0, wb_en}, 1);
    @(negedge clk);
    chk("b2b_en_drop", {31'd0, wb_en}, 0);
    drain("b2b_drain");

    for (int i = 0; i < 14; i++) begin
      drive_accept(mk(vt[i].op, vt[i].rd, 5'd0, vt[i].a, 5'd0, vt[i].b,
                      vt[i].ui, vt[i].urd),
                   vt[i].en, vt[i].rd, vt[i].dat);
      @(negedge clk);
      drain($sformatf("vec%0d_drain", i));
    end

    // SRA by 31: busy for 31 cycles, writeback the cycle after
    drive_accept(mk(4'b1101, 5'd6, 5'd0, 32'h80000000, 5'd0, 32'd31,
                    1'b1, 1'b1), 1'b1, 5'd6, 32'hFFFFFFFF);
    bcnt = 0;
    for (int k = 0; k < 40 && busy; k++) begin
      if (rdy) begin
        checks++;
        fails++;
        $display("FAIL sra_rdy got=1 want=0");
      end
      bcnt++;
      @(negedge clk);
    end
    chk("sra_busy_cycles", bcnt, 31);
    chk("sra_wb_en", {31'd0, wb_en}, 1);
    @(negedge clk);
    drain("sra_drain");

    // SRL with shamt 0 (bit 5 set is ignored)
    drive_accept(mk(4'b0101, 5'd9, 5'd0, 32'h00001234, 5'd0, 32'h20,
                    1'b1, 1'b1), 1'b1, 5'd9, 32'h00001234);
    chk("srl0_busy", {31'd0, busy}, 0);
    chk("srl0_en", {31'd0, wb_en}, 1);
    @(negedge clk);
    drain("srl0_drain");

    // reset in the middle of SLL by 10
    drive_accept(mk(4'b0001, 5'd10, 5'd0, 32'd1, 5'd0, 32'd10, 1'b1, 1'b1),
                 1'b0, 5'd0, 32'd0);
    chk("sll_busy", {31'd0, busy}, 1);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en", {31'd0, wb_en}, 0);
    chk("mid_rst_dat", wb_dat, 0);
    chk("mid_rst_rd", {27'd0, wb_rd}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_rdy", {31'd0, rdy}, 1);
    @(negedge clk);
    drive_accept(mk(4'b0000, 5'd11, 5'd0, 32'd20, 5'd0, 32'd22, 1'b0, 1'b1),
                 1'b1, 5'd11, 32'd42);
    @(negedge clk);
    drain("post_rst_drain");

    // three flavours of invalid bundle
    for (int t = 0; t < 3; t++) begin
      bi = mk(4'b0000, 5'd15, 5'd0, 32'd1, 5'd0, 32'd1, 1'b0, 1'b1);
      if (t == 0) bi.invld_instr = 1'b1;
      if (t == 1) bi.fu_id = 3'd2;
      if (t == 2) bi.alu_op = 4'b1111;
      drive_accept(bi, 1'b0, 5'd0, 32'd0);
      chk($sformatf("trap%0d_set", t), {31'd0, trap}, 1);
      chk($sformatf("trap%0d_rdy", t), {31'd0, rdy}, 0);
      chk($sformatf("trap%0d_en", t), {31'd0, wb_en}, 0);
      instr = mk(4'b0000, 5'd16, 5'd0, 32'd1, 5'd0, 32'd1, 1'b0, 1'b1);
      vld = 1'b1;
      repeat (3) @(negedge clk);
      vld = 1'b0;
      chk($sformatf("trap%0d_hold", t), {31'd0, rdy}, 0);
      rst_n = 1'b0;
      #1;
      chk($sformatf("trap%0d_clr", t), {31'd0, trap}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk($sformatf("trap%0d_rdy_back", t), {31'd0, rdy}, 1);
      @(negedge clk);
    end

    drive_accept(mk(4'b0110, 5'd17, 5'd0, 32'h00F0, 5'd0, 32'h0F00,
                    1'b0, 1'b1), 1'b1, 5'd17, 32'h00000FF0);
    @(negedge clk);
    drain("final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
